// File: rtl/fpu_flag_tracker_pkg.sv
// Shared encodings for the FP flag tracker: rounding modes, fflags bit positions and the
// divide/sqrt tracking FSM state.
package fpu_flag_tracker_pkg;

  localparam int unsigned NfDefault  = 5;
  localparam int unsigned RmwDefault = 3;

  localparam logic [2:0] RmRne = 3'b000;
  localparam logic [2:0] RmRtz = 3'b001;
  localparam logic [2:0] RmRdn = 3'b010;
  localparam logic [2:0] RmRup = 3'b011;
  localparam logic [2:0] RmRmm = 3'b100;
  localparam logic [2:0] RmDyn = 3'b111;

  localparam int unsigned FlagNv = 4;
  localparam int unsigned FlagDz = 3;
  localparam int unsigned FlagOf = 2;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagNx = 0;

  typedef enum logic [1:0] {
    DivIdle,
    DivBusy,
    DivDone
  } div_state_e;

  // 101, 110 and 111 are reserved once the dynamic mode has been resolved.
  function automatic logic rm_reserved(logic [2:0] rm);
    return rm > RmRmm;
  endfunction

endpackage

// File: rtl/fpu_div_flag_fsm.sv
// Tracks one multicycle divide/sqrt from issue to its advance into M and holds its flags.
module fpu_div_flag_fsm
  import fpu_flag_tracker_pkg::*;
#(
  parameter int unsigned NF = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          done_i,
  input  logic [NF-1:0] flags_i,
  input  logic          flush_i,
  input  logic          stall_i,
  output div_state_e    state_o,
  output logic [NF-1:0] flags_o
);

  div_state_e    state_q;
  logic [NF-1:0] flags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DivIdle;
      flags_q <= '0;
    end else begin
      unique case (state_q)
        DivIdle: begin
          if (start_i && !flush_i) begin
            // Zero-latency unit: result arrives in the issue cycle.
            if (done_i) begin
              state_q <= DivDone;
              flags_q <= flags_i;
            end else begin
              state_q <= DivBusy;
            end
          end
        end
        DivBusy: begin
          if (flush_i) begin
            state_q <= DivIdle;
            flags_q <= '0;
          end else if (done_i) begin
            state_q <= DivDone;
            flags_q <= flags_i;
          end
        end
        DivDone: begin
          if (flush_i) begin
            state_q <= DivIdle;
            flags_q <= '0;
          end else if (!stall_i) begin
            state_q <= DivIdle;
          end
        end
        default: begin
          state_q <= DivIdle;
          flags_q <= '0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/fpu_flag_tracker.sv
// E/M-stage FP flag tracker: resolves rounding mode, pipelines exception flags into M and
// interlocks fflags/fcsr CSR accesses against an in-flight divide/sqrt.
module fpu_flag_tracker
  import fpu_flag_tracker_pkg::*;
#(
  parameter int unsigned NF  = NfDefault,
  parameter int unsigned RMW = RmwDefault
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           FPUActiveE,
  input  logic           FlagProdE,
  input  logic [RMW-1:0] FrmE,
  input  logic [RMW-1:0] FRM_REGW,
  input  logic           WriteFRMM,
  input  logic [NF-1:0]  FlagsE,
  input  logic           DivStartE,
  input  logic           DivDoneE,
  input  logic [NF-1:0]  DivFlagsE,
  input  logic           StallE,
  input  logic           StallM,
  input  logic           FlushE,
  input  logic           FlushM,
  input  logic           CSRFflagsAccessE,
  output logic [RMW-1:0] RmE,
  output logic           IllegalFRME,
  output logic           FRMHazardStallE,
  output logic           FlagsBusyStallE,
  output logic [NF-1:0]  SetFflagsM
);

  div_state_e    div_state;
  logic [NF-1:0] div_flags_q;
  logic [NF-1:0] flags_m_d, flags_m_q;
  logic          rm_dyn;
  logic          div_in_e;

  fpu_div_flag_fsm #(
    .NF(NF)
  ) u_div_fsm (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .start_i (DivStartE),
    .done_i  (DivDoneE),
    .flags_i (DivFlagsE),
    .flush_i (FlushE),
    .stall_i (StallE),
    .state_o (div_state),
    .flags_o (div_flags_q)
  );

  assign rm_dyn      = (FrmE == RMW'(RmDyn));
  assign RmE         = rm_dyn ? FRM_REGW : FrmE;
  assign IllegalFRME = FPUActiveE & rm_reserved(3'(RmE));

  // No forwarding of the frm write: stall one cycle until the CSR register updates.
  assign FRMHazardStallE = reset_n & FPUActiveE & rm_dyn & WriteFRMM;

  // The divide itself in its issue cycle must not be blocked by its own tracking.
  assign div_in_e        = DivStartE;
  assign FlagsBusyStallE = reset_n & CSRFflagsAccessE & (div_state != DivIdle) & ~div_in_e;

  always_comb begin
    flags_m_d = flags_m_q;
    if (FlushM) begin
      flags_m_d = '0;
    end else if (!StallM) begin
      if (StallE || FlushE) begin
        flags_m_d = '0;
      end else if (div_state == DivDone) begin
        flags_m_d = div_flags_q;
      end else if (FlagProdE && FPUActiveE && !IllegalFRME) begin
        flags_m_d = FlagsE;
      end else begin
        flags_m_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_m_q <= '0;
    end else begin
      flags_m_q <= flags_m_d;
    end
  end

  assign SetFflagsM = flags_m_q & {NF{~FlushM}};

endmodule

// File: tb/tb_fpu_flag_tracker.sv
// Self-checking bench for fpu_flag_tracker: directed scenarios plus randomized traffic
// against a transaction-level model of the E->M flag stream.
`timescale 1ns/1ps
module tb_fpu_flag_tracker;

  localparam int unsigned NF  = 5;
  localparam int unsigned RMW = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           FPUActiveE, FlagProdE, WriteFRMM, DivStartE, DivDoneE;
  logic           StallE, StallM, FlushE, FlushM, CSRFflagsAccessE;
  logic [RMW-1:0] FrmE, FRM_REGW;
  logic [NF-1:0]  FlagsE, DivFlagsE;
  logic [RMW-1:0] RmE;
  logic           IllegalFRME, FRMHazardStallE, FlagsBusyStallE;
  logic [NF-1:0]  SetFflagsM;

  int checks = 0;
  int errors = 0;

  // Model: the flag word headed for M, and the divide as an outstanding transaction.
  logic [NF-1:0] m_flags;
  bit            m_pend;
  bit            m_ready;
  logic [NF-1:0] m_div_flags;

  always #5 clk = ~clk;

  fpu_flag_tracker #(
    .NF (NF),
    .RMW(RMW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .FPUActiveE       (FPUActiveE),
    .FlagProdE        (FlagProdE),
    .FrmE             (FrmE),
    .FRM_REGW         (FRM_REGW),
    .WriteFRMM        (WriteFRMM),
    .FlagsE           (FlagsE),
    .DivStartE        (DivStartE),
    .DivDoneE         (DivDoneE),
    .DivFlagsE        (DivFlagsE),
    .StallE           (StallE),
    .StallM           (StallM),
    .FlushE           (FlushE),
    .FlushM           (FlushM),
    .CSRFflagsAccessE (CSRFflagsAccessE),
    .RmE              (RmE),
    .IllegalFRME      (IllegalFRME),
    .FRMHazardStallE  (FRMHazardStallE),
    .FlagsBusyStallE  (FlagsBusyStallE),
    .SetFflagsM       (SetFflagsM)
  );

  function automatic logic [RMW-1:0] exp_rm();
    return (FrmE == 3'd7) ? FRM_REGW : FrmE;
  endfunction

  function automatic logic exp_illegal();
    return FPUActiveE && (int'(exp_rm()) >= 5);
  endfunction

  function automatic logic exp_hazard();
    return FPUActiveE && (FrmE == 3'd7) && WriteFRMM;
  endfunction

  function automatic logic exp_busy();
    return CSRFflagsAccessE && (m_pend || m_ready) && !DivStartE;
  endfunction

  function automatic logic [NF-1:0] exp_set();
    return FlushM ? '0 : m_flags;
  endfunction

  function automatic void model_reset();
    m_flags     = '0;
    m_pend      = 1'b0;
    m_ready     = 1'b0;
    m_div_flags = '0;
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  function automatic void model_edge();
    logic [NF-1:0] nf;
    if (FlushM) nf = '0;
    else if (StallM) nf = m_flags;
    else if (StallE || FlushE) nf = '0;
    else if (m_ready) nf = m_div_flags;
    else if (FlagProdE && FPUActiveE && !exp_illegal()) nf = FlagsE;
    else nf = '0;
    if (m_pend || m_ready) begin
      if (FlushE) begin
        m_pend = 1'b0; m_ready = 1'b0; m_div_flags = '0;
      end else if (m_pend && DivDoneE) begin
        m_pend = 1'b0; m_ready = 1'b1; m_div_flags = DivFlagsE;
      end else if (m_ready && !StallE) begin
        m_ready = 1'b0;
      end
    end else if (DivStartE && !FlushE) begin
      if (DivDoneE) begin
        m_ready = 1'b1; m_div_flags = DivFlagsE;
      end else begin
        m_pend = 1'b1;
      end
    end
    m_flags = nf;
  endfunction

  task automatic idle_inputs();
    FPUActiveE = 0; FlagProdE = 0; WriteFRMM = 0; DivStartE = 0; DivDoneE = 0;
    StallE = 0; StallM = 0; FlushE = 0; FlushM = 0; CSRFflagsAccessE = 0;
    FrmE = '0; FRM_REGW = '0; FlagsE = '0; DivFlagsE = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    FPUActiveE = 1; FrmE = 3'd7; WriteFRMM = 1; CSRFflagsAccessE = 1;
    model_reset();
    #12;
    checks++;
    if (SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL reset_set: got %b want 00000", SetFflagsM);
    end
    checks++;
    if (FRMHazardStallE !== 1'b0 || FlagsBusyStallE !== 1'b0) begin
      errors++; $display("FAIL reset_stalls: got %b%b want 00", FRMHazardStallE, FlagsBusyStallE);
    end
    idle_inputs();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dyn_rm();
    FPUActiveE = 1; FrmE = 3'b111; FRM_REGW = 3'b010; FlagProdE = 1; FlagsE = 5'b00100;
    #1;
    checks++;
    if (RmE !== 3'b010 || IllegalFRME !== 1'b0) begin
      errors++; $display("FAIL dyn_rm: got rm=%b ill=%b want rm=010 ill=0", RmE, IllegalFRME);
    end
    FRM_REGW = 3'b101;
    #1;
    checks++;
    if (IllegalFRME !== 1'b1) begin
      errors++; $display("FAIL dyn_rm_reserved: got %b want 1", IllegalFRME);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL illegal_no_flags: got %b want 00000", SetFflagsM);
    end
  endtask

  task automatic test_frm_hazard();
    FPUActiveE = 1; FrmE = 3'b111; FRM_REGW = 3'b001; WriteFRMM = 1;
    #1;
    checks++;
    if (FRMHazardStallE !== 1'b1) begin
      errors++; $display("FAIL frm_hazard_on: got %b want 1", FRMHazardStallE);
    end
    tick();
    WriteFRMM = 0;
    #1;
    checks++;
    if (FRMHazardStallE !== 1'b0) begin
      errors++; $display("FAIL frm_hazard_off: got %b want 0", FRMHazardStallE);
    end
    idle_inputs();
  endtask

  task automatic test_single_flags();
    FPUActiveE = 1; FrmE = 3'b000; FlagProdE = 1; FlagsE = 5'b00001;
    tick();
    FlagProdE = 0; FlagsE = '0; StallM = 1;
    #1;
    checks++;
    if (SetFflagsM !== 5'b00001) begin
      errors++; $display("FAIL single_flags: got %b want 00001", SetFflagsM);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (SetFflagsM !== 5'b00001) begin
        errors++; $display("FAIL stallm_hold%0d: got %b want 00001", i, SetFflagsM);
      end
    end
    FlushM = 1;
    #1;
    checks++;
    if (SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL flushm_gate: got %b want 00000", SetFflagsM);
    end
    tick();
    FlushM = 0; StallM = 0;
    #1;
    checks++;
    if (SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL flushm_clear: got %b want 00000", SetFflagsM);
    end
    FlagProdE = 1; FlagsE = 5'b10100;
    tick();
    FlagProdE = 0;
    tick();
    checks++;
    if (SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL flags_once: got %b want 00000", SetFflagsM);
    end
    idle_inputs();
  endtask

  task automatic test_divide();
    FPUActiveE = 1; DivStartE = 1; CSRFflagsAccessE = 1;
    #1;
    checks++;
    if (FlagsBusyStallE !== 1'b0) begin
      errors++; $display("FAIL div_issue_nostall: got %b want 0", FlagsBusyStallE);
    end
    tick();
    DivStartE = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (FlagsBusyStallE !== 1'b1) begin
        errors++; $display("FAIL div_busy_stall%0d: got %b want 1", i, FlagsBusyStallE);
      end
      tick();
    end
    DivDoneE = 1; DivFlagsE = 5'b01000; StallE = 1;
    tick();
    DivDoneE = 0; DivFlagsE = '0;
    tick();
    checks++;
    if (FlagsBusyStallE !== 1'b1 || SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL div_done_stalled: got stall=%b set=%b want 1 00000",
                         FlagsBusyStallE, SetFflagsM);
    end
    StallE = 0;
    tick();
    checks++;
    if (SetFflagsM !== 5'b01000 || FlagsBusyStallE !== 1'b0) begin
      errors++; $display("FAIL div_flags: got set=%b stall=%b want 01000 0",
                         SetFflagsM, FlagsBusyStallE);
    end
    tick();
    checks++;
    if (SetFflagsM !== 5'b0) begin
      errors++; $display("FAIL div_flags_once: got %b want 00000", SetFflagsM);
    end
    idle_inputs();
  endtask

  task automatic test_div_abort();
    logic [NF-1:0] seen;
    seen = '0;
    FPUActiveE = 1; DivStartE = 1;
    tick();
    DivStartE = 0;
    tick();
    tick();
    DivDoneE = 1; FlushE = 1; DivFlagsE = 5'b10000;
    tick();
    idle_inputs();
    CSRFflagsAccessE = 1;
    #1;
    checks++;
    if (FlagsBusyStallE !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got %b want 0", FlagsBusyStallE);
    end
    for (int i = 0; i < 4; i++) begin
      seen = seen | SetFflagsM;
      tick();
    end
    checks++;
    if (seen !== 5'b0) begin
      errors++; $display("FAIL abort_no_flags: got %b want 00000", seen);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    FPUActiveE = 1; FlagProdE = 1; FlagsE = 5'b00010; DivStartE = 1;
    tick();
    FlagProdE = 0; FlagsE = '0; DivStartE = 0;
    CSRFflagsAccessE = 1; FrmE = 3'b111; WriteFRMM = 1;
    #1;
    checks++;
    if (FlagsBusyStallE !== 1'b1 || SetFflagsM !== 5'b00010 || FRMHazardStallE !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got busy=%b set=%b haz=%b want 1 00010 1",
                         FlagsBusyStallE, SetFflagsM, FRMHazardStallE);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (SetFflagsM !== 5'b0 || FlagsBusyStallE !== 1'b0 || FRMHazardStallE !== 1'b0) begin
      errors++; $display("FAIL async_reset: got set=%b busy=%b haz=%b want 00000 0 0",
                         SetFflagsM, FlagsBusyStallE, FRMHazardStallE);
    end
    #3 reset_n = 1'b1;
    idle_inputs();
    model_reset();
    CSRFflagsAccessE = 1;
    #1;
    checks++;
    if (FlagsBusyStallE !== 1'b0) begin
      errors++; $display("FAIL reset_fsm_idle: got %b want 0", FlagsBusyStallE);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      FPUActiveE       = ($urandom_range(0, 9) < 8);
      FlagProdE        = $urandom_range(0, 1);
      FrmE             = 3'($urandom);
      FRM_REGW         = 3'($urandom);
      WriteFRMM        = ($urandom_range(0, 9) == 0);
      FlagsE           = 5'($urandom);
      StallE           = ($urandom_range(0, 6) == 0);
      StallM           = ($urandom_range(0, 6) == 0);
      FlushE           = ($urandom_range(0, 19) == 0);
      FlushM           = ($urandom_range(0, 19) == 0);
      CSRFflagsAccessE = ($urandom_range(0, 4) == 0);
      DivFlagsE        = 5'($urandom);
      DivStartE        = 0;
      DivDoneE         = 0;
      if (!m_pend && !m_ready) begin
        DivStartE = ($urandom_range(0, 7) == 0);
        DivDoneE  = DivStartE && ($urandom_range(0, 4) == 0);
      end else if (m_pend) begin
        DivDoneE = ($urandom_range(0, 3) == 0);
      end
      #1;
      checks++;
      if (RmE !== exp_rm() || IllegalFRME !== exp_illegal()) begin
        errors++; $display("FAIL rand_rm[%0d]: got rm=%b ill=%b want rm=%b ill=%b",
                           n, RmE, IllegalFRME, exp_rm(), exp_illegal());
      end
      checks++;
      if (FRMHazardStallE !== exp_hazard() || FlagsBusyStallE !== exp_busy()) begin
        errors++; $display("FAIL rand_stalls[%0d]: got haz=%b busy=%b want haz=%b busy=%b",
                           n, FRMHazardStallE, FlagsBusyStallE, exp_hazard(), exp_busy());
      end
      checks++;
      if (SetFflagsM !== exp_set()) begin
        errors++; $display("FAIL rand_set[%0d]: got %b want %b", n, SetFflagsM, exp_set());
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dyn_rm();
    test_frm_hazard();
    test_single_flags();
    test_divide();
    test_div_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_flag_tracker.md
Name: fpu_flag_tracker

Overview:
- Execute/memory-stage companion to the user-mode FP CSR block. It consumes the FP CSR's FRM value and write strobes, and produces the per-instruction exception-flag stream (SetFflagsM) that the CSR block accumulates into fflags.
- It resolves the dynamic rounding mode and flags reserved rounding modes as illegal.
- It pipelines FPU flags from E to M under stall and flush.
- It tracks a multicycle divide/sqrt through completion and interlocks fflags/fcsr CSR accesses against it.

Parameters:
- NF, 5, width of the FP exception-flag vector {NV,DZ,OF,UF,NX}.
- RMW, 3, width of a rounding-mode field.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- FPUActiveE  in  1  FP instruction valid in E
- FlagProdE  in  1  E instruction produces fflags (single-cycle FPU op)
- FrmE  in  RMW  instruction rm field in E
- FRM_REGW  in  RMW  current frm CSR value
- WriteFRMM  in  1  frm/fcsr write in M this cycle
- FlagsE  in  NF  single-cycle FPU flags, valid with FlagProdE
- DivStartE  in  1  div/sqrt begins this cycle
- DivDoneE  in  1  div/sqrt result and flags valid this cycle
- DivFlagsE  in  NF  div/sqrt flags, valid with DivDoneE
- StallE, StallM, FlushE, FlushM  in  1 each  pipeline controls
- CSRFflagsAccessE  in  1  E instruction reads or writes fflags or fcsr
- RmE  out  RMW  resolved rounding mode
- IllegalFRME  out  1  reserved rounding mode
- FRMHazardStallE  out  1  stall request, dynamic rm vs in-flight frm write
- FlagsBusyStallE  out  1  stall request, CSR flag access vs div in flight
- SetFflagsM  out  NF  flags to OR into fflags

Behaviour:
Rounding-mode resolution (combinational):
- RmE = (FrmE == 3'b111) ? FRM_REGW : FrmE.
- IllegalFRME = FPUActiveE & (RmE ∈ {3'b101, 3'b110, 3'b111}). This covers a reserved static rm and a dynamic rm with a reserved FRM_REGW.
- FRMHazardStallE = FPUActiveE & (FrmE == 3'b111) & WriteFRMM. It lasts exactly one cycle because the frm register updates at that edge; there is no forwarding of the write value.

Divide FSM, states IDLE, BUSY, DONE; reset state is IDLE:
- IDLE -> BUSY on DivStartE & ~FlushE.
- BUSY -> DONE on DivDoneE. DivFlagsE is captured into DivFlagsQ.
- BUSY & DivStartE is a protocol error: ignore it and stay in BUSY.
- DONE -> IDLE when ~StallE; the div instruction advances to M.
- FlushE in BUSY or DONE -> IDLE with DivFlagsQ cleared, so flags are discarded. FlushE has priority over DivDoneE in the same cycle.
- DivStartE & DivDoneE in IDLE (zero-latency case): treated as DONE directly, with flags captured.

Interlock:
- FlagsBusyStallE = CSRFflagsAccessE & (state != IDLE) & ~DivInE, where DivInE marks the div itself occupying E.
- The CSR requester stalls until the FSM returns to IDLE.

E->M flag register FlagsM:
- Reset value 0.
- On FlushM: 0.
- Else if ~StallM, with StallE or FlushE: 0 (bubble).
- Else if ~StallM: the state is DONE ? DivFlagsQ : (FlagProdE & FPUActiveE & ~IllegalFRME ? FlagsE : 0).
- StallM holds the value.
- FlushM has priority over StallM.

Output and reset:
- SetFflagsM = FlagsM & {NF{~FlushM}}. Latency is exactly one edge from E to M. Each instruction's flags appear once.
- Reset while BUSY: the FSM goes to IDLE immediately, DivFlagsQ = 0, FlagsM = 0, SetFflagsM = 0, and both stall outputs drop to 0.
- All combinational outputs are 0 when their enabling inputs are 0.

Decomposition:
- Shared package: the rounding-mode encodings (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111) and the flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
- A package-scope typedef for the divide FSM state enum.
- One sub-module, fpu_div_flag_fsm: the IDLE/BUSY/DONE FSM plus DivFlagsQ. All other logic stays in the top.
- Reuse the existing async-reset enable flop primitives.

Test Plan:
1. Dynamic rounding mode: FrmE=111, FRM_REGW=010 -> RmE=010, IllegalFRME=0. Then FRM_REGW=101 -> IllegalFRME=1, and next cycle SetFflagsM=0.
2. FRM hazard: FrmE=111 with WriteFRMM=1 -> FRMHazardStallE=1 for exactly one cycle. It drops once WriteFRMM deasserts.
3. Single-cycle flags: FlagsE=00001 with FlagProdE=1, no stalls -> SetFflagsM=00001 on the next cycle and 0 the cycle after. With StallM held 3 cycles, the value stays 00001 for all 3. FlushM -> 0.
4. Divide path: DivStartE, then 10 cycles, then DivDoneE with DivFlagsE=01000 -> SetFflagsM=01000 one cycle after StallE drops. A CSRFflagsAccessE in that window -> FlagsBusyStallE=1 until the FSM reaches IDLE.
5. Divide abort: FlushE in BUSY with DivDoneE in the same cycle -> FSM goes to IDLE and SetFflagsM never shows DivFlagsE.
6. Async reset mid-divide: reset_n low for half a cycle while BUSY -> FSM IDLE, SetFflagsM=0 and stalls 0 immediately, without a clock edge.
